// File: rtl/tlb_pkg.sv
// Shared widths, entry layout and FSM encoding for the set-associative TLB.
// TLB_ASSOC_GLOBAL_EN adds a per-entry global bit.
package tlb_pkg;

    // Entry fields are stored at these widths; narrower configurations zero-extend.
    localparam int ENTRY_TAG_W  = 64;
    localparam int ENTRY_PCID_W = 16;
    localparam int ENTRY_PPN_W  = 64;

    function automatic int vpn_w(input int addr, input int page);
        return addr - page;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr, input int page, input int sets);
        return vpn_w(addr, page) - idx_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return $clog2(ways);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tlb_state_t;

    typedef struct packed {
        logic                    valid;
`ifdef TLB_ASSOC_GLOBAL_EN
        logic                    glob;
`endif
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [ENTRY_PCID_W-1:0] pcid;
        logic [ENTRY_PPN_W-1:0]  ppn;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_assoc_plru_tree.sv
// Tree pseudo-LRU for one set: heap-ordered node bits, 0 steers the victim left.
module plru_tree #(
    parameter int WAYS = 8,
    parameter int WW   = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] plru_bits,
    input  logic [WW-1:0]   access_way,
    output logic [WW-1:0]   victim_way,
    output logic [WAYS-2:0] plru_next
);

    // Follow the node bits from the root down to the victim leaf.
    always_comb begin
        int node;
        node       = 0;
        victim_way = '0;
        for (int l = 0; l < WW; l++) begin
            victim_way[WW-1-l] = plru_bits[WW'(node)];
            node = 2 * node + 1 + int'(plru_bits[WW'(node)]);
        end
    end

    // Point every node on the accessed way's path away from that way.
    always_comb begin
        int node;
        node      = 0;
        plru_next = plru_bits;
        for (int l = 0; l < WW; l++) begin
            plru_next[WW'(node)] = ~access_way[WW-1-l];
            node = 2 * node + 1 + int'(access_way[WW-1-l]);
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// PCID-tagged set-associative TLB with PLRU replacement and a set-walking flush.
// Define TLB_ASSOC_GLOBAL_EN for global entries and the fill_global input.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int ADDR   = 64,
    parameter int PAGE   = 12,
    parameter int PCID_W = 12,
    parameter int WAYS   = 8,
    parameter int SETS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lk_valid,
    output logic                 lk_ready,
    input  logic [ADDR-1:0]      lk_vaddr,
    input  logic [PCID_W-1:0]    lk_pcid,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [ADDR-1:0]      rsp_paddr,
    input  logic                 fill_valid,
    input  logic [ADDR-PAGE-1:0] fill_vpn,
    input  logic [PCID_W-1:0]    fill_pcid,
    input  logic [ADDR-PAGE-1:0] fill_ppn,
`ifdef TLB_ASSOC_GLOBAL_EN
    input  logic                 fill_global,
`endif
    input  logic                 flush_valid,
    output logic                 flush_ready,
    input  logic                 flush_all,
    input  logic [PCID_W-1:0]    flush_pcid
);

    localparam int VW = vpn_w(ADDR, PAGE);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(ADDR, PAGE, SETS);
    localparam int WW = way_w(WAYS);

    tlb_entry_t          entries_r [SETS][WAYS];
    logic [WAYS-2:0]     plru_r [SETS];
    tlb_state_t          state_r;
    logic [IW-1:0]       fidx_r;
    logic                flush_all_r;
    logic [PCID_W-1:0]   flush_pcid_r;

    logic [IW-1:0]       lk_idx_s, fill_idx_s, plru_set_s;
    logic [TW-1:0]       lk_tag_s, fill_tag_s;
    logic                idle_s, lk_fire_s;
    logic [WAYS-1:0]     lk_match_s, fill_dup_s, fill_inv_s, flush_clr_s;
    logic                hit_s, dup_s, has_inv_s;
    logic [WW-1:0]       hit_way_s, dup_way_s, inv_way_s, fill_way_s;
    logic [WW-1:0]       victim_s, access_way_s;
    logic [WAYS-2:0]     plru_next_s;
    logic [ENTRY_PPN_W-1:0] hit_ppn_s;
    tlb_entry_t          new_entry_s;

    assign lk_idx_s    = lk_vaddr[PAGE+IW-1:PAGE];
    assign lk_tag_s    = lk_vaddr[ADDR-1:PAGE+IW];
    assign fill_idx_s  = fill_vpn[IW-1:0];
    assign fill_tag_s  = fill_vpn[VW-1:IW];
    assign idle_s      = (state_r == ST_IDLE);
    assign lk_ready    = idle_s && !fill_valid && !flush_valid;
    assign lk_fire_s   = lk_valid && lk_ready;
    assign flush_ready = idle_s;
    assign hit_ppn_s   = entries_r[lk_idx_s][hit_way_s].ppn;

    // A fill and an accepted lookup never coexist, so one PLRU tree serves both.
    assign plru_set_s   = fill_valid ? fill_idx_s : lk_idx_s;
    assign access_way_s = fill_valid ? fill_way_s : hit_way_s;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_bits  (plru_r[plru_set_s]),
        .access_way (access_way_s),
        .victim_way (victim_s),
        .plru_next  (plru_next_s)
    );

    // Per-way match vectors for the lookup set, the fill set and the set being flushed.
    always_comb begin
        lk_match_s  = '0;
        fill_dup_s  = '0;
        fill_inv_s  = '0;
        flush_clr_s = '0;
        for (int w = 0; w < WAYS; w++) begin
`ifdef TLB_ASSOC_GLOBAL_EN
            lk_match_s[w]  = entries_r[lk_idx_s][WW'(w)].valid
                          && (entries_r[lk_idx_s][WW'(w)].tag == ENTRY_TAG_W'(lk_tag_s))
                          && (entries_r[lk_idx_s][WW'(w)].glob
                              || entries_r[lk_idx_s][WW'(w)].pcid == ENTRY_PCID_W'(lk_pcid));
            fill_dup_s[w]  = entries_r[fill_idx_s][WW'(w)].valid
                          && (entries_r[fill_idx_s][WW'(w)].tag == ENTRY_TAG_W'(fill_tag_s))
                          && (entries_r[fill_idx_s][WW'(w)].glob || fill_global
                              || entries_r[fill_idx_s][WW'(w)].pcid == ENTRY_PCID_W'(fill_pcid));
            flush_clr_s[w] = flush_all_r
                          || (!entries_r[fidx_r][WW'(w)].glob
                              && entries_r[fidx_r][WW'(w)].pcid == ENTRY_PCID_W'(flush_pcid_r));
`else
            lk_match_s[w]  = entries_r[lk_idx_s][WW'(w)].valid
                          && (entries_r[lk_idx_s][WW'(w)].tag == ENTRY_TAG_W'(lk_tag_s))
                          && (entries_r[lk_idx_s][WW'(w)].pcid == ENTRY_PCID_W'(lk_pcid));
            fill_dup_s[w]  = entries_r[fill_idx_s][WW'(w)].valid
                          && (entries_r[fill_idx_s][WW'(w)].tag == ENTRY_TAG_W'(fill_tag_s))
                          && (entries_r[fill_idx_s][WW'(w)].pcid == ENTRY_PCID_W'(fill_pcid));
            flush_clr_s[w] = flush_all_r
                          || (entries_r[fidx_r][WW'(w)].pcid == ENTRY_PCID_W'(flush_pcid_r));
`endif
            fill_inv_s[w]  = !entries_r[fill_idx_s][WW'(w)].valid;
        end
    end

    // Lowest-index encoders and fill target: duplicate, then free way, then PLRU victim.
    always_comb begin
        hit_s     = |lk_match_s;
        dup_s     = |fill_dup_s;
        has_inv_s = |fill_inv_s;
        hit_way_s = '0;
        dup_way_s = '0;
        inv_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = lk_match_s[w] ? WW'(w) : hit_way_s;
            dup_way_s = fill_dup_s[w] ? WW'(w) : dup_way_s;
            inv_way_s = fill_inv_s[w] ? WW'(w) : inv_way_s;
        end
        fill_way_s = dup_s ? dup_way_s : (has_inv_s ? inv_way_s : victim_s);
    end

    // Entry image written by a fill.
    always_comb begin
        new_entry_s       = '0;
        new_entry_s.valid = 1'b1;
`ifdef TLB_ASSOC_GLOBAL_EN
        new_entry_s.glob  = fill_global;
`endif
        new_entry_s.tag   = ENTRY_TAG_W'(fill_tag_s);
        new_entry_s.pcid  = ENTRY_PCID_W'(fill_pcid);
        new_entry_s.ppn   = ENTRY_PPN_W'(fill_ppn);
    end

    // Entry and PLRU storage: flush clears one set per cycle, otherwise fill or hit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    entries_r[s][w] <= '0;
                end
            end
        end else if (state_r == ST_FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                if (flush_clr_s[w]) begin
                    entries_r[fidx_r][WW'(w)].valid <= 1'b0;
                end
            end
            plru_r[fidx_r] <= '0;
        end else if (fill_valid) begin
            entries_r[fill_idx_s][fill_way_s] <= new_entry_s;
            plru_r[fill_idx_s]                <= plru_next_s;
        end else if (lk_fire_s && hit_s) begin
            plru_r[lk_idx_s] <= plru_next_s;
        end
    end

    // Control FSM and registered lookup response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fidx_r       <= '0;
            flush_all_r  <= 1'b0;
            flush_pcid_r <= '0;
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_paddr    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= lk_fire_s;
                    rsp_hit   <= lk_fire_s && hit_s;
                    rsp_paddr <= (lk_fire_s && hit_s)
                                 ? ADDR'({hit_ppn_s, lk_vaddr[PAGE-1:0]}) : '0;
                    if (flush_valid) begin
                        state_r      <= ST_FLUSH;
                        fidx_r       <= '0;
                        flush_all_r  <= flush_all;
                        flush_pcid_r <= flush_pcid;
                    end
                end
                ST_FLUSH: begin
                    rsp_valid <= 1'b0;
                    rsp_hit   <= 1'b0;
                    rsp_paddr <= '0;
                    if (fidx_r == IW'(SETS - 1)) begin
                        state_r <= ST_IDLE;
                        fidx_r  <= '0;
                    end else begin
                        fidx_r  <= fidx_r + 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    fidx_r    <= '0;
                    rsp_valid <= 1'b0;
                    rsp_hit   <= 1'b0;
                    rsp_paddr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc in its default configuration (8 sets x 8 ways).
module tb_tlb_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid, lk_ready;
    logic [63:0] lk_vaddr;
    logic [11:0] lk_pcid;
    logic        rsp_valid, rsp_hit;
    logic [63:0] rsp_paddr;
    logic        fill_valid;
    logic [51:0] fill_vpn, fill_ppn;
    logic [11:0] fill_pcid;
    logic        flush_valid, flush_ready, flush_all;
    logic [11:0] flush_pcid;

    typedef struct {
        logic        hit;
        logic [63:0] paddr;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    tlb_assoc dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_vaddr(lk_vaddr), .lk_pcid(lk_pcid),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_paddr(rsp_paddr),
        .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_pcid(fill_pcid), .fill_ppn(fill_ppn),
`ifdef TLB_ASSOC_GLOBAL_EN
        .fill_global(1'b0),
`endif
        .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_all(flush_all), .flush_pcid(flush_pcid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_addr(input logic [51:0] pn, input logic [11:0] off);
        return {pn, off};
    endfunction

    // Responses are compared on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
                check_eq("rsp_paddr", rsp_paddr, e.paddr);
            end
        end
    end

    task automatic clear_inputs();
        lk_valid    = 1'b0;
        fill_valid  = 1'b0;
        flush_valid = 1'b0;
        flush_all   = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] va, input logic [11:0] pcid,
                          input logic exp_hit, input logic [51:0] exp_ppn);
        rsp_t e;
        @(negedge clk);
        clear_inputs();
        lk_valid = 1'b1;
        lk_vaddr = va;
        lk_pcid  = pcid;
        #1;
        check_eq("lk_ready_idle", {63'd0, lk_ready}, 64'd1);
        e.hit   = exp_hit;
        e.paddr = exp_hit ? mk_addr(exp_ppn, va[11:0]) : 64'd0;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic fill(input logic [51:0] vpn, input logic [11:0] pcid, input logic [51:0] ppn);
        @(negedge clk);
        clear_inputs();
        fill_valid = 1'b1;
        fill_vpn   = vpn;
        fill_pcid  = pcid;
        fill_ppn   = ppn;
        @(posedge clk);
    endtask

    task automatic do_flush(input logic all, input logic [11:0] pcid);
        int busy;
        busy = 0;
        @(negedge clk);
        clear_inputs();
        flush_valid = 1'b1;
        flush_all   = all;
        flush_pcid  = pcid;
        #1;
        check_eq("flush_req_lk_ready", {63'd0, lk_ready}, 64'd0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            if (lk_ready) break;
            busy++;
        end
        check_eq("flush_busy_cycles", 64'(busy), 64'd8);
        check_eq("flush_ready_after", {63'd0, flush_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        lk_vaddr = '0; lk_pcid = '0; fill_vpn = '0; fill_pcid = '0; fill_ppn = '0; flush_pcid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_rsp_hit", {63'd0, rsp_hit}, 64'd0);
        check_eq("rst_rsp_paddr", rsp_paddr, 64'd0);
        check_eq("rst_lk_ready", {63'd0, lk_ready}, 64'd1);
        check_eq("rst_flush_ready", {63'd0, flush_ready}, 64'd1);
        rst_n = 1'b1;

        // Cold miss, then fill and hit; other PCID misses.
        lookup(64'h0000_0000_0040_3123, 12'd5, 1'b0, 52'd0);
        fill(52'h403, 12'd5, 52'h9A);
        lookup(64'h0000_0000_0040_3123, 12'd5, 1'b1, 52'h9A);
        lookup(64'h0000_0000_0040_3123, 12'd6, 1'b0, 52'd0);

        // Set 3: VPN 0x403 already in way 0; ways 1..7 get k=1..7, way 0 is touched,
        // so the ninth fill (k=8) replaces way 4 (k=4).
        for (int k = 1; k <= 7; k++) fill(52'((k << 3) | 3), 12'd5, 52'(12'h100 + k));
        lookup(mk_addr(52'h403, 12'h0ab), 12'd5, 1'b1, 52'h9A);
        fill(52'((8 << 3) | 3), 12'd5, 52'h108);
        lookup(mk_addr(52'h403, 12'h0ab), 12'd5, 1'b1, 52'h9A);
        lookup(mk_addr(52'((4 << 3) | 3), 12'h0ab), 12'd5, 1'b0, 52'd0);
        lookup(mk_addr(52'((8 << 3) | 3), 12'h0ab), 12'd5, 1'b1, 52'h108);
        lookup(mk_addr(52'((3 << 3) | 3), 12'h0ab), 12'd5, 1'b1, 52'h103);
        lookup(mk_addr(52'((7 << 3) | 3), 12'hfff), 12'd5, 1'b1, 52'h107);

        // Selective flush of PCID 1 keeps PCID 2 and PCID 5 entries.
        fill(52'h111, 12'd1, 52'h11);
        fill(52'h222, 12'd2, 52'h22);
        do_flush(1'b0, 12'd1);
        lookup(mk_addr(52'h111, 12'h456), 12'd1, 1'b0, 52'd0);
        lookup(mk_addr(52'h222, 12'h456), 12'd2, 1'b1, 52'h22);
        lookup(mk_addr(52'h403, 12'h123), 12'd5, 1'b1, 52'h9A);

        // Flush-all removes everything.
        do_flush(1'b1, 12'd0);
        lookup(mk_addr(52'h222, 12'h456), 12'd2, 1'b0, 52'd0);
        lookup(mk_addr(52'h403, 12'h123), 12'd5, 1'b0, 52'd0);

        // Lookup blocked by a same-cycle fill, then retried.
        @(negedge clk);
        clear_inputs();
        lk_valid = 1'b1; lk_vaddr = mk_addr(52'h555, 12'habc); lk_pcid = 12'd7;
        fill_valid = 1'b1; fill_vpn = 52'h555; fill_pcid = 12'd7; fill_ppn = 52'h77;
        #1;
        check_eq("fill_blocks_lookup", {63'd0, lk_ready}, 64'd0);
        @(posedge clk);
        lookup(mk_addr(52'h555, 12'habc), 12'd7, 1'b1, 52'h77);

        // Reset in the fourth flush cycle.
        fill(52'h666, 12'd3, 52'h66);
        lookup(mk_addr(52'h666, 12'h001), 12'd3, 1'b1, 52'h66);
        @(negedge clk);
        clear_inputs();
        flush_valid = 1'b1; flush_all = 1'b0; flush_pcid = 12'd9;
        @(posedge clk);
        repeat (4) @(negedge clk);
        clear_inputs();
        #1;
        check_eq("mid_flush_busy", {63'd0, flush_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("midrst_rsp_paddr", rsp_paddr, 64'd0);
        check_eq("midrst_lk_ready", {63'd0, lk_ready}, 64'd1);
        check_eq("midrst_flush_ready", {63'd0, flush_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(mk_addr(52'h555, 12'habc), 12'd7, 1'b0, 52'd0);
        lookup(mk_addr(52'h666, 12'h001), 12'd3, 1'b0, 52'd0);
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
